// File: rtl/qick_alu_sched.sv
// qick_alu_sched: round-robin sharing of one iterative divider and one
// multiply-accumulate unit among N_REQ requesters. Each unit has its own
// IDLE/START/WAIT/DONE FSM; results return on one tagged response port.
module qick_alu_sched #(
    parameter int  N_REQ     = 4,
    parameter int  DIV_LAT   = 33,
    parameter int  ARITH_LAT = 3,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [6*N_REQ-1:0]  req_op_i,
    input  logic [32*N_REQ-1:0] req_a_i,
    input  logic [32*N_REQ-1:0] req_b_i,
    input  logic [32*N_REQ-1:0] req_c_i,
    input  logic [32*N_REQ-1:0] req_d_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic                rsp_valid_o,
    output logic [IDW-1:0]      rsp_id_o,
    output logic [63:0]         rsp_data_o,
    output logic                rsp_dz_o,
    output logic                div_start_o,
    output logic [31:0]         div_a_o,
    output logic [31:0]         div_b_o,
    input  logic [31:0]         div_quot_i,
    input  logic [31:0]         div_rem_i,
    output logic                arith_start_o,
    output logic [4:0]          arith_op_o,
    output logic [31:0]         arith_a_o,
    output logic [31:0]         arith_b_o,
    output logic [31:0]         arith_c_o,
    output logic [31:0]         arith_d_o,
    input  logic [63:0]         arith_result_i,
    output logic                div_busy_o,
    output logic                arith_busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;

    localparam logic [15:0] DIV_LOAD   = 16'(DIV_LAT - 1);
    localparam logic [15:0] ARITH_LOAD = 16'(ARITH_LAT - 1);

    state_t           div_state, arith_state;
    logic [IDW-1:0]   div_ptr, arith_ptr, div_pick, arith_pick, div_id, arith_id;
    logic [N_REQ-1:0] div_elig, arith_elig;
    logic [15:0]      div_cnt, arith_cnt;
    logic [63:0]      div_hold, arith_hold;
    logic             div_dz;
    logic [31:0]      sel_div_a, sel_div_b;
    logic [4:0]       sel_op;
    logic [31:0]      sel_a, sel_b, sel_c, sel_d;

    // First eligible requester strictly after ptr, wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] pick;
        pick = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            if (elig[(int'(ptr) + k) % N_REQ]) pick = IDW'((int'(ptr) + k) % N_REQ);
        end
        return pick;
    endfunction

    // Split requests by target unit, arbitrate and mux the winners' operands.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            div_elig[i]   = req_valid_i[i] &  req_op_i[6*i+5];
            arith_elig[i] = req_valid_i[i] & ~req_op_i[6*i+5];
        end
        div_pick   = rr_pick(div_elig, div_ptr);
        arith_pick = rr_pick(arith_elig, arith_ptr);
        sel_div_a  = req_a_i[32*int'(div_pick) +: 32];
        sel_div_b  = req_b_i[32*int'(div_pick) +: 32];
        sel_op     = req_op_i[6*int'(arith_pick) +: 5];
        sel_a      = req_a_i[32*int'(arith_pick) +: 32];
        sel_b      = req_b_i[32*int'(arith_pick) +: 32];
        sel_c      = req_c_i[32*int'(arith_pick) +: 32];
        sel_d      = req_d_i[32*int'(arith_pick) +: 32];
    end

    // Accept pulse: one per idle unit with an eligible requester, never in reset.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        req_ready_o = '0;
        if (!rst_i) begin
            if (div_state == ST_IDLE && |div_elig)     req_ready_o[div_pick]   = 1'b1;
            if (arith_state == ST_IDLE && |arith_elig) req_ready_o[arith_pick] = 1'b1;
        end
    end

    // Divider FSM: accept, pulse start, count latency, hold result until the port is free.
    always_ff @(posedge clk_i) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            div_state <= ST_IDLE;
            div_ptr   <= IDW'(N_REQ - 1);
            div_id    <= '0;
            div_cnt   <= '0;
            div_a_o   <= '0;
            div_b_o   <= '0;
            div_hold  <= '0;
            div_dz    <= 1'b0;
        end else begin
            case (div_state)
                ST_IDLE: if (|div_elig) begin
                    div_a_o <= sel_div_a;
                    div_b_o <= sel_div_b;
                    div_id  <= div_pick;
                    div_ptr <= div_pick;
                    if (sel_div_b == 32'd0) begin
                        div_hold  <= {sel_div_a, 32'hFFFF_FFFF};
                        div_dz    <= 1'b1;
                        div_state <= ST_DONE;
                    end else begin
                        div_dz    <= 1'b0;
                        div_state <= ST_START;
                    end
                end
                ST_START: begin
                    div_cnt   <= DIV_LOAD;
                    div_state <= ST_WAIT;
                end
                ST_WAIT: if (div_cnt == 16'd0) begin
                    div_hold  <= {div_rem_i, div_quot_i};
                    div_state <= ST_DONE;
                end else begin
                    div_cnt <= div_cnt - 16'd1;
                end
                ST_DONE: if (arith_state != ST_DONE) div_state <= ST_IDLE;
                default: div_state <= ST_IDLE;
            endcase
        end
    end

    // Arith FSM: same flow; it always owns the response port when in DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arith_state <= ST_IDLE;
            arith_ptr   <= IDW'(N_REQ - 1);
            arith_id    <= '0;
            arith_cnt   <= '0;
            arith_op_o  <= '0;
            arith_a_o   <= '0;
            arith_b_o   <= '0;
            arith_c_o   <= '0;
            arith_d_o   <= '0;
            arith_hold  <= '0;
        end else begin
            case (arith_state)
                ST_IDLE: if (|arith_elig) begin
                    arith_op_o  <= sel_op;
                    arith_a_o   <= sel_a;
                    arith_b_o   <= sel_b;
                    arith_c_o   <= sel_c;
                    arith_d_o   <= sel_d;
                    arith_id    <= arith_pick;
                    arith_ptr   <= arith_pick;
                    arith_state <= ST_START;
                end
                ST_START: begin
                    arith_cnt   <= ARITH_LOAD;
                    arith_state <= ST_WAIT;
                end
                ST_WAIT: if (arith_cnt == 16'd0) begin
                    arith_hold  <= arith_result_i;
                    arith_state <= ST_DONE;
                end else begin
                    arith_cnt <= arith_cnt - 16'd1;
                end
                ST_DONE: arith_state <= ST_IDLE;
                default: arith_state <= ST_IDLE;
            endcase
        end
    end

    // Response port: arith DONE wins, div DONE waits one cycle.
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_id_o    = '0;
        rsp_data_o  = '0;
        rsp_dz_o    = 1'b0;
        if (!rst_i) begin
            if (arith_state == ST_DONE) begin
                rsp_valid_o = 1'b1;
                rsp_id_o    = arith_id;
                rsp_data_o  = arith_hold;
            end else if (div_state == ST_DONE) begin
                rsp_valid_o = 1'b1;
                rsp_id_o    = div_id;
                rsp_data_o  = div_hold;
                rsp_dz_o    = div_dz;
            end
        end
    end

    assign div_start_o   = !rst_i && (div_state == ST_START);
    assign arith_start_o = !rst_i && (arith_state == ST_START);
    assign div_busy_o    = (div_state != ST_IDLE);
    assign arith_busy_o  = (arith_state != ST_IDLE);

endmodule

// File: tb/tb_qick_alu_sched.sv
// Testbench for qick_alu_sched: behavioural unit models with exact latency,
// a negedge monitor that logs accepts/starts/responses, and scenario tasks
// that compare the logs against expectations computed from operands.
module tb_qick_alu_sched;

    localparam int N   = 4;
    localparam int DL  = 33;
    localparam int AL  = 3;
    localparam int IDW = 2;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [N-1:0]     req_valid_i;
    logic [6*N-1:0]   req_op_i;
    logic [32*N-1:0]  req_a_i, req_b_i, req_c_i, req_d_i;
    logic [N-1:0]     req_ready_o;
    logic             rsp_valid_o, rsp_dz_o;
    logic [IDW-1:0]   rsp_id_o;
    logic [63:0]      rsp_data_o;
    logic             div_start_o, arith_start_o, div_busy_o, arith_busy_o;
    logic [31:0]      div_a_o, div_b_o, div_quot_i, div_rem_i;
    logic [4:0]       arith_op_o;
    logic [31:0]      arith_a_o, arith_b_o, arith_c_o, arith_d_o;
    logic [63:0]      arith_result_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    qick_alu_sched #(.N_REQ(N), .DIV_LAT(DL), .ARITH_LAT(AL)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i), .req_d_i(req_d_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_dz_o(rsp_dz_o),
        .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
        .arith_start_o(arith_start_o), .arith_op_o(arith_op_o),
        .arith_a_o(arith_a_o), .arith_b_o(arith_b_o), .arith_c_o(arith_c_o), .arith_d_o(arith_d_o),
        .arith_result_i(arith_result_i),
        .div_busy_o(div_busy_o), .arith_busy_o(arith_busy_o)
    );

    // Requester-side state, packed onto the DUT ports.
    logic        p_valid [N];
    logic [5:0]  p_op [N];
    logic [31:0] p_a [N], p_b [N], p_c [N], p_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]        = p_valid[i];
            req_op_i[6*i +: 6]    = p_op[i];
            req_a_i[32*i +: 32]   = p_a[i];
            req_b_i[32*i +: 32]   = p_b[i];
            req_c_i[32*i +: 32]   = p_c[i];
            req_d_i[32*i +: 32]   = p_d[i];
        end
    end

    // Arith unit behaviour: opcode 2 is P = C + A*B; other opcodes just need a distinct value.
    function automatic logic [63:0] unit_fn(input logic [4:0] op, input logic [31:0] a, b, c, d);
        if (op == 5'b00010) return 64'(c) + 64'(a) * 64'(b);
        return {a ^ d, b ^ c} + 64'(op);
    endfunction

    // Expected {dz, data} for a request, straight from the operand rules.
    function automatic logic [64:0] ref_rsp(input logic [5:0] op, input logic [31:0] a, b, c, d);
        if (op[5]) begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
        end
        return {1'b0, unit_fn(op[4:0], a, b, c, d)};
    endfunction

    function automatic logic [31:0] rnd_nz();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 28);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // Unit models: results are valid only in exactly the cycle start + LAT.
    int          cyc = 0;
    int          m_ddue = -1, m_adue = -1;
    logic [31:0] m_da = 0, m_db = 1, m_aa = 0, m_ab = 0, m_ac = 0, m_ad = 0;
    logic [4:0]  m_aop = 0;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (div_start_o) begin
            m_da <= div_a_o; m_db <= div_b_o; m_ddue <= cyc + DL;
        end
        if (arith_start_o) begin
            m_aop <= arith_op_o; m_aa <= arith_a_o; m_ab <= arith_b_o;
            m_ac <= arith_c_o; m_ad <= arith_d_o; m_adue <= cyc + AL;
        end
    end

    assign div_quot_i     = (cyc == m_ddue && m_db != 0) ? m_da / m_db : 32'hDEAD_BEEF;
    assign div_rem_i      = (cyc == m_ddue && m_db != 0) ? m_da % m_db : 32'hDEAD_BEEF;
    assign arith_result_i = (cyc == m_adue) ? unit_fn(m_aop, m_aa, m_ab, m_ac, m_ad)
                                            : 64'hBAD0_BAD0_BAD0_BAD0;

    // Event logs.
    typedef struct { int cyc; int id; logic unit_div; logic [63:0] exp_data; logic exp_dz; } acc_t;
    typedef struct { int cyc; int id; logic [63:0] data; logic dz; } rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    int          dstart_q[$], astart_q[$];
    int          last_acc [N] = '{default: -10};
    int          last_div_id = N - 1;
    acc_t        mon_e;
    rsp_t        mon_s;
    logic [64:0] mon_r;

    always @(negedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (req_ready_o[i]) begin
                mon_r          = ref_rsp(p_op[i], p_a[i], p_b[i], p_c[i], p_d[i]);
                mon_e.cyc      = cyc;
                mon_e.id       = i;
                mon_e.unit_div = p_op[i][5];
                mon_e.exp_data = mon_r[63:0];
                mon_e.exp_dz   = mon_r[64];
                acc_q.push_back(mon_e);
                last_acc[i] = cyc;
                if (p_op[i][5]) last_div_id = i;
            end
        end
        if (div_start_o)   dstart_q.push_back(cyc);
        if (arith_start_o) astart_q.push_back(cyc);
        if (rsp_valid_o) begin
            mon_s.cyc = cyc; mon_s.id = int'(rsp_id_o); mon_s.data = rsp_data_o; mon_s.dz = rsp_dz_o;
            rsp_q.push_back(mon_s);
        end
    end

    // Advance one cycle; a requester accepted last cycle drops its valid.
    task automatic tick();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) if (last_acc[i] == cyc - 1) p_valid[i] = 1'b0;
        #1;
    endtask

    task automatic issue(input int i, input logic [5:0] op, input logic [31:0] a, b, c, d);
        p_op[i] = op; p_a[i] = a; p_b[i] = b; p_c[i] = c; p_d[i] = d;
        p_valid[i] = 1'b1;
    endtask

    task automatic clear_logs();
        acc_q.delete(); rsp_q.delete(); dstart_q.delete(); astart_q.delete();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        issue(3, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        issue(0, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        repeat (2) tick();
        @(negedge clk_i);
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL reset_ready: got %0h expected 0", req_ready_o); end
        checks++; if ({rsp_valid_o, rsp_dz_o, div_start_o, arith_start_o, div_busy_o, arith_busy_o} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %0b expected 0",
                {rsp_valid_o, rsp_dz_o, div_start_o, arith_start_o, div_busy_o, arith_busy_o}); end
        checks++; if ({rsp_id_o, rsp_data_o, div_a_o, div_b_o} !== '0) begin
            errors++; $display("FAIL reset_data: got %0h expected 0", {rsp_id_o, rsp_data_o, div_a_o, div_b_o}); end
        checks++; if ({arith_op_o, arith_a_o, arith_b_o, arith_c_o, arith_d_o} !== '0) begin
            errors++; $display("FAIL reset_arith_ops: got %0h expected 0", {arith_op_o, arith_a_o, arith_b_o, arith_c_o, arith_d_o}); end
        tick();
        clear_logs();
        rst_i = 1'b0;
        repeat (80) tick();
        checks++; if (acc_q.size() != 2 || rsp_q.size() != 2) begin
            errors++; $display("FAIL reset_first_counts: got %0d/%0d expected 2/2", acc_q.size(), rsp_q.size()); return; end
        checks++; if (acc_q[0].id != 0 || acc_q[1].id != 3) begin
            errors++; $display("FAIL reset_first_order: got %0d,%0d expected 0,3", acc_q[0].id, acc_q[1].id); end
        checks++; if (acc_q[1].cyc - acc_q[0].cyc != DL + 3) begin
            errors++; $display("FAIL reset_issue_interval: got %0d expected %0d", acc_q[1].cyc - acc_q[0].cyc, DL + 3); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (rsp_q[k].id != acc_q[k].id || rsp_q[k].data !== acc_q[k].exp_data || rsp_q[k].cyc != acc_q[k].cyc + DL + 2) begin
                errors++; $display("FAIL reset_first_rsp%0d: got id %0d data %0h cyc %0d expected id %0d data %0h cyc %0d",
                    k, rsp_q[k].id, rsp_q[k].data, rsp_q[k].cyc, acc_q[k].id, acc_q[k].exp_data, acc_q[k].cyc + DL + 2); end
        end
    endtask

    task automatic test_div_basic();
        int rid;
        clear_logs();
        issue(2, 6'h20, 32'd100, 32'd7, $urandom, $urandom);
        repeat (12) tick();
        @(negedge clk_i);
        checks++; if (div_a_o !== 32'd100 || div_b_o !== 32'd7 || div_busy_o !== 1'b1) begin
            errors++; $display("FAIL div_hold_operands: got a %0d b %0d busy %0b expected 100 7 1", div_a_o, div_b_o, div_busy_o); end
        repeat (33) tick();
        checks++; if (acc_q.size() != 1 || rsp_q.size() != 1 || dstart_q.size() != 1) begin
            errors++; $display("FAIL div_basic_counts: got %0d/%0d/%0d expected 1/1/1", acc_q.size(), rsp_q.size(), dstart_q.size()); return; end
        checks++; if (acc_q[0].id != 2) begin errors++; $display("FAIL div_basic_acc_id: got %0d expected 2", acc_q[0].id); end
        checks++; if (dstart_q[0] != acc_q[0].cyc + 1) begin
            errors++; $display("FAIL div_basic_start: got %0d expected %0d", dstart_q[0], acc_q[0].cyc + 1); end
        checks++; if (rsp_q[0].cyc != acc_q[0].cyc + 35) begin
            errors++; $display("FAIL div_basic_rsp_cycle: got %0d expected %0d", rsp_q[0].cyc, acc_q[0].cyc + 35); end
        checks++; if (rsp_q[0].id != 2 || rsp_q[0].data !== {32'd2, 32'd14} || rsp_q[0].dz !== 1'b0) begin
            errors++; $display("FAIL div_basic_rsp: got id %0d data %0h dz %0b expected 2 %0h 0", rsp_q[0].id, rsp_q[0].data, rsp_q[0].dz, {32'd2, 32'd14}); end
        for (int t = 0; t < 3; t++) begin
            clear_logs();
            rid = $urandom_range(0, N - 1);
            issue(rid, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
            repeat (40) tick();
            checks++; if (rsp_q.size() != 1 || acc_q.size() != 1) begin
                errors++; $display("FAIL div_rand%0d_count: got %0d expected 1", t, rsp_q.size()); end
            else if (rsp_q[0].id != rid || rsp_q[0].data !== acc_q[0].exp_data || rsp_q[0].dz !== 1'b0) begin
                errors++; $display("FAIL div_rand%0d_rsp: got id %0d data %0h expected id %0d data %0h", t, rsp_q[0].id, rsp_q[0].data, rid, acc_q[0].exp_data); end
        end
    endtask

    task automatic test_arith();
        clear_logs();
        issue(1, 6'b000010, 32'd3, 32'd5, 32'd10, $urandom);
        tick();
        issue(0, {1'b0, 5'($urandom)}, $urandom, $urandom, $urandom, $urandom);
        repeat (20) tick();
        checks++; if (acc_q.size() != 2 || rsp_q.size() != 2 || astart_q.size() != 2) begin
            errors++; $display("FAIL arith_counts: got %0d/%0d/%0d expected 2/2/2", acc_q.size(), rsp_q.size(), astart_q.size()); return; end
        checks++; if (acc_q[0].id != 1 || acc_q[1].id != 0) begin
            errors++; $display("FAIL arith_order: got %0d,%0d expected 1,0", acc_q[0].id, acc_q[1].id); end
        checks++; if (acc_q[1].cyc - acc_q[0].cyc != AL + 3) begin
            errors++; $display("FAIL arith_back_to_back: got %0d expected %0d", acc_q[1].cyc - acc_q[0].cyc, AL + 3); end
        checks++; if (astart_q[0] != acc_q[0].cyc + 1) begin
            errors++; $display("FAIL arith_start: got %0d expected %0d", astart_q[0], acc_q[0].cyc + 1); end
        checks++; if (rsp_q[0].cyc != acc_q[0].cyc + 5 || rsp_q[0].id != 1 || rsp_q[0].data !== 64'd25 || rsp_q[0].dz !== 1'b0) begin
            errors++; $display("FAIL arith_mac: got cyc %0d id %0d data %0h dz %0b expected cyc %0d id 1 data 19 dz 0",
                rsp_q[0].cyc, rsp_q[0].id, rsp_q[0].data, rsp_q[0].dz, acc_q[0].cyc + 5); end
        checks++; if (rsp_q[1].cyc != acc_q[1].cyc + 5 || rsp_q[1].id != 0 || rsp_q[1].data !== acc_q[1].exp_data) begin
            errors++; $display("FAIL arith_second: got cyc %0d id %0d data %0h expected cyc %0d id 0 data %0h",
                rsp_q[1].cyc, rsp_q[1].id, rsp_q[1].data, acc_q[1].cyc + 5, acc_q[1].exp_data); end
    endtask

    task automatic test_round_robin();
        int first;
        clear_logs();
        first = (last_div_id + 1) % N;
        for (int i = 0; i < N; i++) issue(i, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        repeat (185) begin
            tick();
            for (int i = 0; i < N; i++) if (!p_valid[i]) issue(i, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        end
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        repeat (40) tick();
        checks++; if (acc_q.size() < 5 || rsp_q.size() != acc_q.size()) begin
            errors++; $display("FAIL rr_counts: got acc %0d rsp %0d expected >=5 equal", acc_q.size(), rsp_q.size()); return; end
        checks++; if (acc_q[0].id != first) begin errors++; $display("FAIL rr_first: got %0d expected %0d", acc_q[0].id, first); end
        for (int k = 1; k < acc_q.size(); k++) begin
            checks++; if (acc_q[k].id != (acc_q[k-1].id + 1) % N || acc_q[k].cyc - acc_q[k-1].cyc != DL + 3) begin
                errors++; $display("FAIL rr_step%0d: got id %0d gap %0d expected id %0d gap %0d", k, acc_q[k].id,
                    acc_q[k].cyc - acc_q[k-1].cyc, (acc_q[k-1].id + 1) % N, DL + 3); end
        end
        for (int k = 0; k < rsp_q.size(); k++) begin
            checks++; if (rsp_q[k].id != acc_q[k].id || rsp_q[k].data !== acc_q[k].exp_data) begin
                errors++; $display("FAIL rr_rsp%0d: got id %0d data %0h expected id %0d data %0h", k, rsp_q[k].id, rsp_q[k].data, acc_q[k].id, acc_q[k].exp_data); end
        end
    endtask

    task automatic test_concurrent();
        clear_logs();
        issue(1, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        repeat (30) tick();
        issue(3, {1'b0, 5'($urandom)}, $urandom, $urandom, $urandom, $urandom);
        repeat (45) tick();
        checks++; if (acc_q.size() != 2 || rsp_q.size() != 2) begin
            errors++; $display("FAIL conc_counts: got %0d/%0d expected 2/2", acc_q.size(), rsp_q.size()); return; end
        checks++; if (acc_q[0].id != 1 || acc_q[1].id != 3 || acc_q[1].cyc - acc_q[0].cyc != 30) begin
            errors++; $display("FAIL conc_accepts: got %0d,%0d gap %0d expected 1,3 gap 30", acc_q[0].id, acc_q[1].id, acc_q[1].cyc - acc_q[0].cyc); end
        checks++; if (rsp_q[0].cyc != acc_q[0].cyc + 35 || rsp_q[0].id != 3 || rsp_q[0].data !== acc_q[1].exp_data) begin
            errors++; $display("FAIL conc_arith_first: got cyc %0d id %0d data %0h expected cyc %0d id 3 data %0h",
                rsp_q[0].cyc, rsp_q[0].id, rsp_q[0].data, acc_q[0].cyc + 35, acc_q[1].exp_data); end
        checks++; if (rsp_q[1].cyc != acc_q[0].cyc + 36 || rsp_q[1].id != 1 || rsp_q[1].data !== acc_q[0].exp_data) begin
            errors++; $display("FAIL conc_div_delayed: got cyc %0d id %0d data %0h expected cyc %0d id 1 data %0h",
                rsp_q[1].cyc, rsp_q[1].id, rsp_q[1].data, acc_q[0].cyc + 36, acc_q[0].exp_data); end
    endtask

    task automatic test_div_zero();
        clear_logs();
        issue(3, 6'h20, 32'h1234, 32'd0, $urandom, $urandom);
        tick();
        issue(2, 6'h20, $urandom, 32'd0, $urandom, $urandom);
        repeat (8) tick();
        checks++; if (acc_q.size() != 2 || rsp_q.size() != 2) begin
            errors++; $display("FAIL dz_counts: got %0d/%0d expected 2/2", acc_q.size(), rsp_q.size()); return; end
        checks++; if (dstart_q.size() != 0) begin errors++; $display("FAIL dz_no_start: got %0d starts expected 0", dstart_q.size()); end
        checks++; if (rsp_q[0].cyc != acc_q[0].cyc + 1 || rsp_q[0].id != 3 || rsp_q[0].data !== {32'h1234, 32'hFFFF_FFFF} || rsp_q[0].dz !== 1'b1) begin
            errors++; $display("FAIL dz_first: got cyc %0d id %0d data %0h dz %0b expected cyc %0d id 3 data 1234ffffffff dz 1",
                rsp_q[0].cyc, rsp_q[0].id, rsp_q[0].data, rsp_q[0].dz, acc_q[0].cyc + 1); end
        checks++; if (acc_q[1].cyc - acc_q[0].cyc != 2 || rsp_q[1].cyc != acc_q[1].cyc + 1 || rsp_q[1].data !== acc_q[1].exp_data || rsp_q[1].dz !== 1'b1) begin
            errors++; $display("FAIL dz_second: got gap %0d data %0h dz %0b expected gap 2 data %0h dz 1",
                acc_q[1].cyc - acc_q[0].cyc, rsp_q[1].data, rsp_q[1].dz, acc_q[1].exp_data); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        issue(2, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        repeat (12) tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got valid %0b ready %0h expected 0 0", rsp_valid_o, req_ready_o); end
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({div_busy_o, arith_busy_o, div_start_o} !== 3'b0) begin
            errors++; $display("FAIL rst_mid_idle: got %0b expected 0", {div_busy_o, arith_busy_o, div_start_o}); end
        repeat (40) tick();
        checks++; if (rsp_q.size() != 0 || dstart_q.size() != 1) begin
            errors++; $display("FAIL rst_mid_discard: got rsp %0d starts %0d expected 0 1", rsp_q.size(), dstart_q.size()); end
        clear_logs();
        issue(2, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        issue(0, 6'h20, $urandom, rnd_nz(), $urandom, $urandom);
        repeat (80) tick();
        checks++; if (acc_q.size() != 2 || rsp_q.size() != 2) begin
            errors++; $display("FAIL rst_mid_after_counts: got %0d/%0d expected 2/2", acc_q.size(), rsp_q.size()); return; end
        checks++; if (acc_q[0].id != 0 || acc_q[1].id != 2) begin
            errors++; $display("FAIL rst_mid_priority: got %0d,%0d expected 0,2", acc_q[0].id, acc_q[1].id); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (rsp_q[k].id != acc_q[k].id || rsp_q[k].data !== acc_q[k].exp_data) begin
                errors++; $display("FAIL rst_mid_rsp%0d: got id %0d data %0h expected id %0d data %0h", k, rsp_q[k].id, rsp_q[k].data, acc_q[k].id, acc_q[k].exp_data); end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; p_c[i] = '0; p_d[i] = '0;
        end
        test_reset();
        test_div_basic();
        test_arith();
        test_round_robin();
        test_concurrent();
        test_div_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
